// File: rtl/adder_result_sink.sv
`default_nettype none
// ============================================================================
// Module   : adder_result_sink
// Brief    : Aligns an issue strobe to the 2-bit pipelined adder latency, packs
//            {Cout,S2,S1}, buffers results in a FIFO, keeps a running sum and
//            drop statistics. Optional result checker: ADDER_RESULT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adder_result_sink #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4,
    parameter int ACC_W   = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [1:0]       in_a,
    input  logic [1:0]       in_b,
    input  logic             in_cin,
    input  logic             S1,
    input  logic             S2,
    input  logic             Cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_data,
    input  logic             acc_clear,
    output logic [ACC_W-1:0] acc,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             mismatch
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [c_CNT_BITS-1:0] c_DEPTH_CNT = c_CNT_BITS'(DEPTH);
    localparam logic [CNT_W-1:0]      c_DROP_MAX  = {CNT_W{1'b1}};

    logic [LATENCY-1:0]    r_v_dly;
    logic [2:0]            r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_BITS-1:0] r_count;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_overflow;
    logic [CNT_W-1:0]      r_drop_cnt;

    logic       w_v_al;
    logic [2:0] w_res;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;

    assign w_v_al = r_v_dly[LATENCY-1];
    assign w_res  = {Cout, S2, S1};
    assign w_pop  = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push = w_v_al && ((r_count < c_DEPTH_CNT) || w_pop);
    assign w_drop = w_v_al && !w_push;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_v_dly <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_v_dly[i] <= r_v_dly[i-1];
            end
            r_v_dly[0] <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (acc_clear) begin
            r_acc      <= w_push ? {{(ACC_W-3){1'b0}}, w_res} : '0;
            r_overflow <= w_drop;
            r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
        end else begin
            if (w_push) begin
                r_acc <= r_acc + {{(ACC_W-3){1'b0}}, w_res};
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != c_DROP_MAX) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 3'd0;
    assign acc       = r_acc;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

`ifdef ADDER_RESULT_CHECK_EN
    logic [1:0] r_a_dly   [LATENCY];
    logic [1:0] r_b_dly   [LATENCY];
    logic       r_cin_dly [LATENCY];
    logic       r_mismatch;
    logic [2:0] w_exp;

    // Operand line is free-running; only the compare is qualified by w_v_al.
    always_ff @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) begin
            r_a_dly[i]   <= r_a_dly[i-1];
            r_b_dly[i]   <= r_b_dly[i-1];
            r_cin_dly[i] <= r_cin_dly[i-1];
        end
        r_a_dly[0]   <= in_a;
        r_b_dly[0]   <= in_b;
        r_cin_dly[0] <= in_cin;
    end

    assign w_exp = {1'b0, r_a_dly[LATENCY-1]} + {1'b0, r_b_dly[LATENCY-1]}
                 + {2'b00, r_cin_dly[LATENCY-1]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mismatch <= 1'b0;
        end else if (w_v_al && (w_res != w_exp)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_ops;
    assign w_unused_ops = ^{in_a, in_b, in_cin};
    assign mismatch     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_result_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_result_sink
// Brief    : Directed bench for adder_result_sink with a behavioural adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_result_sink;

    localparam int LAT = 4;

    logic       clk;
    logic       rstn;
    logic       in_valid;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic       in_cin;
    logic       S1;
    logic       S2;
    logic       Cout;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       acc_clear;
    logic [7:0] acc;
    logic       overflow;
    logic [3:0] drop_cnt;
    logic       mismatch;

    adder_result_sink #(
        .LATENCY(LAT),
        .DEPTH  (4),
        .ACC_W  (8),
        .CNT_W  (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .S1       (S1),
        .S2       (S2),
        .Cout     (Cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .acc_clear(acc_clear),
        .acc      (acc),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       cin;
        logic [2:0] res;
        logic [7:0] acc;
    } vec_t;

    vec_t vecs [8];

    // Behavioural adder: hist[k] is the issue made k cycles ago.
    logic [2:0] hist [LAT+1];

    int n_pass  = 0;
    int n_total = 0;

    logic rdy_q;
    logic clr_q;
    logic rst_q;

    int       cyc;
    int       pops;
    int       bad_pops;
    int       valid_cycles;
    int       first_pop;
    int       last_pop_cyc;
    int       last_pop_val;
    int       exp_pop_val;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        pops         = 0;
        bad_pops     = 0;
        valid_cycles = 0;
        first_pop    = -1;
        last_pop_cyc = -1;
        last_pop_val = -1;
    endtask

    task automatic step(input logic v, input logic [1:0] a, input logic [1:0] b,
                        input logic cin, input logic flt);
        logic [2:0] sum;
        @(negedge clk);
        cyc++;
        for (int k = LAT; k > 0; k--) begin
            hist[k] = hist[k-1];
        end
        sum     = {1'b0, a} + {1'b0, b} + {2'b00, cin};
        hist[0] = v ? (sum ^ {2'b00, flt}) : 3'd0;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = rdy_q;
        acc_clear = clr_q;
        rstn      = rst_q;
        {Cout, S2, S1} = hist[LAT];
        if (out_valid) begin
            valid_cycles++;
        end
        if (out_valid && out_ready) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop_cyc = cyc;
            last_pop_val = int'(out_data);
            if (int'(out_data) != exp_pop_val) bad_pops++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{2'd3, 2'd2, 1'b1, 3'd6, 8'd6};
        vecs[1] = '{2'd1, 2'd1, 1'b0, 3'd2, 8'd8};
        vecs[2] = '{2'd0, 2'd0, 1'b0, 3'd0, 8'd8};
        vecs[3] = '{2'd3, 2'd3, 1'b1, 3'd7, 8'd15};
        vecs[4] = '{2'd2, 2'd1, 1'b0, 3'd3, 8'd18};
        vecs[5] = '{2'd1, 2'd2, 1'b1, 3'd4, 8'd22};
        vecs[6] = '{2'd3, 2'd0, 1'b1, 3'd4, 8'd26};
        vecs[7] = '{2'd0, 2'd1, 1'b1, 3'd2, 8'd28};

        for (int k = 0; k <= LAT; k++) hist[k] = 3'd0;
        cyc = 0; exp_pop_val = 0;
        clr_stats();
        in_valid = 1'b0; in_a = 2'd0; in_b = 2'd0; in_cin = 1'b0;
        {Cout, S2, S1} = 3'd0;
        out_ready = 1'b0; acc_clear = 1'b0; rstn = 1'b0;
        rdy_q = 1'b0; clr_q = 1'b0; rst_q = 1'b0;

        idle(2);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data), 0);
        chk("rst_acc",       int'(acc), 0);
        chk("rst_overflow",  int'(overflow), 0);
        chk("rst_drop_cnt",  int'(drop_cnt), 0);
        chk("rst_mismatch",  int'(mismatch), 0);

        // Isolated results, consumer always ready
        rst_q = 1'b1; rdy_q = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            idle(LAT);
            chk("vec_pre_valid", int'(out_valid), 0);
            idle(1);
            chk("vec_valid", int'(out_valid), 1);
            chk("vec_data",  int'(out_data), int'(vecs[i].res));
            chk("vec_acc",   int'(acc), int'(vecs[i].acc));
        end

        // Streaming: 8 back-to-back results of 2
        idle(2);
        clr_stats(); exp_pop_val = 2;
        for (int i = 0; i < 8; i++) step(1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
        idle(LAT + 3);
        chk("stream_pops", pops, 8);
        chk("stream_bad",  bad_pops, 0);
        chk("stream_gapless", last_pop_cyc - first_pop + 1, 8);
        chk("stream_acc",  int'(acc), 44);
        chk("stream_ovf",  int'(overflow), 0);

        // Full / drop
        clr_q = 1'b1; idle(1); clr_q = 1'b0; idle(1);
        chk("clr_acc",  int'(acc), 0);
        chk("clr_ovf",  int'(overflow), 0);
        chk("clr_drop", int'(drop_cnt), 0);
        rdy_q = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
        idle(LAT + 1);
        chk("full_valid", int'(out_valid), 1);
        chk("full_acc",   int'(acc), 4);
        chk("full_ovf",   int'(overflow), 1);
        chk("full_drop",  int'(drop_cnt), 2);
        clr_stats(); exp_pop_val = 1; rdy_q = 1'b1;
        idle(8);
        chk("drain_pops",  pops, 4);
        chk("drain_bad",   bad_pops, 0);
        chk("drain_empty", int'(out_valid), 0);

        // Refill to full, then push exactly when the head pops
        rdy_q = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
        idle(LAT + 1);
        chk("refill_acc", int'(acc), 8);
        step(1'b1, 2'd3, 2'd2, 1'b0, 1'b0);
        idle(LAT - 1);
        rdy_q = 1'b1; idle(1); rdy_q = 1'b0; idle(1);
        chk("simul_acc",  int'(acc), 13);
        chk("simul_drop", int'(drop_cnt), 2);
        chk("simul_ovf",  int'(overflow), 1);
        clr_stats(); exp_pop_val = 1; rdy_q = 1'b1;
        idle(8);
        chk("simul_pops", pops, 4);
        chk("simul_last", last_pop_val, 5);

        // acc_clear coincident with an accepted push of 7
        step(1'b1, 2'd3, 2'd3, 1'b1, 1'b0);
        idle(LAT - 1);
        clr_q = 1'b1; idle(1); clr_q = 1'b0; idle(1);
        chk("clrpush_acc",  int'(acc), 7);
        chk("clrpush_drop", int'(drop_cnt), 0);
        chk("clrpush_ovf",  int'(overflow), 0);
        idle(3);

        // Reset with three results in flight
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
        rst_q = 1'b0; idle(1); rst_q = 1'b1;
        clr_stats();
        idle(LAT + 4);
        chk("inflight_valid_cycles", valid_cycles, 0);
        chk("inflight_acc", int'(acc), 0);

        // Checker: corrupt S1 of a 0+0+0 result
        chk("chk_pre", int'(mismatch), 0);
        step(1'b1, 2'd0, 2'd0, 1'b0, 1'b1);
        idle(LAT);
        chk("chk_at_val", int'(mismatch), 0);
        idle(1);
`ifdef ADDER_RESULT_CHECK_EN
        chk("chk_set", int'(mismatch), 1);
        idle(3);
        chk("chk_sticky", int'(mismatch), 1);
`else
        chk("chk_off", int'(mismatch), 0);
        idle(3);
        chk("chk_off_later", int'(mismatch), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_result_sink.md
Name: adder_result_sink

Overview:
- Downstream consumer of the 2-bit pipelined adder (fixed 4-cycle latency, outputs S1/S2/Cout).
- Re-aligns an upstream issue strobe to the adder latency and packs each result as {Cout,S2,S1}.
- Buffers results in a small FIFO with a valid/ready output, and keeps a running accumulator plus drop statistics.
- The adder cannot stall, so the sink absorbs its output stream and records any result it is forced to discard.

Parameters:
- LATENCY, 4: cycles from operand issue to valid adder outputs.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ACC_W, 8: accumulator width.
- CNT_W, 4: drop counter width.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous reset, active low.
- in_valid  in  1  high in the cycle operands are presented to the adder.
- in_a  in  2  operand A {A2,A1}; used only by the checker.
- in_b  in  2  operand B {B2,B1}; used only by the checker.
- in_cin  in  1  carry-in; used only by the checker.
- S1  in  1  adder sum bit 0.
- S2  in  1  adder sum bit 1.
- Cout  in  1  adder carry out.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  3  head result {Cout,S2,S1}, range 0..7.
- acc_clear  in  1  clears acc, overflow and drop_cnt.
- acc  out  ACC_W  wrap-around sum of all accepted results.
- overflow  out  1  sticky: at least one result dropped.
- drop_cnt  out  CNT_W  dropped results, saturating.
- mismatch  out  1  sticky checker error.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - Clears the valid delay line, FIFO pointers and count, acc, overflow, drop_cnt and mismatch.
  - Output values: out_valid=0, out_data=0, acc=0, overflow=0, drop_cnt=0, mismatch=0.
  - Results in flight inside the adder at reset are never enqueued.
- Alignment:
  - v_al is in_valid delayed by exactly LATENCY registers.
  - When v_al=1, S1/S2/Cout are sampled combinationally in that same cycle as res={Cout,S2,S1}.
  - in_valid at cycle t gives a push at the edge ending cycle t+LATENCY.
  - Back-to-back issue is allowed every cycle.
- FIFO:
  - Registered storage, no bypass. The earliest out_valid is cycle t+LATENCY+1.
  - out_data holds its value while out_valid=1 and out_ready=0.
  - out_data is don't-care when out_valid=0; the bench must not check it.
  - Pop occurs when out_valid and out_ready are both 1.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Push rules:
  - Push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle (count stays DEPTH).
  - Otherwise the result is dropped: overflow<=1, and drop_cnt increments, saturating at 2^CNT_W-1.
  - A dropped result is never added to acc.
- Simultaneous push and pop at count 1..DEPTH-1: count is unchanged, both operations happen.
- Accumulator:
  - On an accepted push, acc <= acc + res, modulo 2^ACC_W.
  - acc_clear=1 sets acc to 0; if an accepted push occurs in the same cycle, acc <= res.
  - acc_clear also clears overflow and drop_cnt. A drop in the same cycle as acc_clear leaves overflow=1 and drop_cnt=1.
  - acc_clear does not affect the FIFO or mismatch.
- Checker:
  - Active only with the optional feature compiled in.
  - The exp delay line is always clocked (operands delayed LATENCY cycles); the comparison is gated by v_al.

Optional Feature:
- Macro: ADDER_RESULT_CHECK_EN.
- Defined:
  - in_a, in_b and in_cin are delayed LATENCY cycles alongside in_valid.
  - When v_al=1 and res != in_a+in_b+in_cin (3-bit), mismatch<=1.
  - mismatch is sticky until reset.
  - The check also runs on results that are dropped.
- Undefined:
  - Operand delay registers are not generated.
  - mismatch is tied 0; in_a, in_b and in_cin are ignored.

Test Plan:
- Single result: rstn released, out_ready=1; in_valid pulse at cycle 2 with A=3, B=2, Cin=1. S/Cout come from the adder at cycle 6 = {1,1,0} → push at end of cycle 6; out_valid=1 with out_data=6 at cycle 7; acc=6; mismatch=0.
- Streaming: in_valid for 8 consecutive cycles, all operands A=1, B=1, Cin=0 (result 2), out_ready=1 → 8 pops of out_data=2, no gaps; acc=16; overflow=0.
- Full/drop: out_ready=0, 6 consecutive results of 1 (A=1, B=0, Cin=0) with DEPTH=4 → count=4, acc=4, overflow=1, drop_cnt=2. Then out_ready=1 → exactly 4 pops of value 1.
- Full with simultaneous pop: FIFO full; out_ready=1 in the same cycle as a push of 5 → push accepted, count stays 4, no drop, acc increases by 5.
- Clear and reset: acc_clear in the same cycle as an accepted push of 7 → acc=7, drop_cnt=0, overflow=0. rstn low for 1 cycle while 3 results are in flight → none appear; out_valid=0, acc=0.
- Checker (ADDER_RESULT_CHECK_EN defined): the bench forces S1 to be inverted for one result (A=0, B=0, Cin=0) → mismatch=1 one cycle after v_al and remains 1; with the macro undefined, mismatch stays 0.
